// File: rtl/led_pkg.sv
// led_pkg
//   Shared defaults and helpers for the LED fade driver.
//   - DEF_*      : default parameter values for the driver and its channels
//   - LEVEL_MAX  : full-brightness level for the default PWM width
//   - level_max  : full-brightness level for an arbitrary PWM width
//   - fdiv_width : counter width needed to count 0..n-1
package led_pkg;

    localparam int DEF_NUM_LEDS  = 8;
    localparam int DEF_PWM_BITS  = 8;
    localparam int DEF_FADE_DIV  = 50000;
    localparam int DEF_FADE_STEP = 16;

    localparam int LEVEL_MAX = (2 ** DEF_PWM_BITS) - 1;

    function automatic int level_max(input int pwm_bits);
        return (2 ** pwm_bits) - 1;
    endfunction

    function automatic int fdiv_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel
//   One LED channel: brightness level with load/fade, master scaling,
//   per-period shadow latch and PWM comparator.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   i_led                 : scanner bit for this LED (1 = lit)
//   i_fade_tick           : one-cycle strobe that decrements the level
//   i_latch               : last-count-of-period strobe, loads the shadow duty
//   i_pwm_cnt             : shared PWM counter
//   i_master_brightness   : global brightness scale
//   o_led                 : registered PWM drive for this LED
module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int FADE_STEP = DEF_FADE_STEP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                i_led,
    input  logic                i_fade_tick,
    input  logic                i_latch,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    input  logic [PWM_BITS-1:0] i_master_brightness,
    output logic                o_led
);

    localparam int                PW      = PWM_BITS;
    localparam logic [PW-1:0]     LVL_MAX = '1;
    localparam logic [PW-1:0]     STEP    = PW'(FADE_STEP);

    logic [PW-1:0] r_level_p0;
    logic [PW-1:0] r_shadow_p1;
    logic          r_led_p2;

    // Decrement that stops at zero instead of wrapping to a bright value.
    function automatic logic [PW-1:0] fade_sat(input logic [PW-1:0] lvl);
        return (lvl > STEP) ? (lvl - STEP) : '0;
    endfunction

    // level * (mb + 1) >> PW; the +1 makes mb = all-ones an exact pass-through.
    function automatic logic [PW-1:0] scale(input logic [PW-1:0] lvl,
                                            input logic [PW-1:0] mb);
        logic [2*PW:0] prod;
        prod = (2*PW+1)'(lvl) * ((2*PW+1)'(mb) + (2*PW+1)'(1));
        return prod[2*PW-1:PW];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            r_level_p0  <= '0;
            r_shadow_p1 <= '0;
            r_led_p2    <= 1'b0;
        end else begin
            // stage p0: level, load has priority over fade
            if (i_led) begin
                r_level_p0 <= LVL_MAX;
            end else if (i_fade_tick) begin
                r_level_p0 <= fade_sat(r_level_p0);
            end

            // stage p1: duty only changes at a period boundary
            if (i_latch) begin
                r_shadow_p1 <= scale(r_level_p0, i_master_brightness);
            end

            // stage p2: comparator output to pin
            r_led_p2 <= (i_pwm_cnt < r_shadow_p1);
        end
    end

    assign o_led = r_led_p2;

endmodule

// File: rtl/led_fade_driver.sv
// led_fade_driver
//   Turns the scanner's one-hot pattern into per-LED PWM with a fading tail.
//   Holds the shared fade divider and PWM counter; each LED is a
//   led_pwm_channel instance.
// Ports:
//   clock              : system clock
//   reset              : synchronous active-high reset
//   leds_in            : scanner pattern, bit high = LED lit
//   master_brightness  : global scale, all-ones = unscaled
//   led_out            : registered PWM drive to the pins
//   period_start       : pulse aligned with the led_out sample for count 0
module led_fade_driver
    import led_pkg::*;
#(
    parameter int NUM_LEDS  = DEF_NUM_LEDS,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int FADE_DIV  = DEF_FADE_DIV,
    parameter int FADE_STEP = DEF_FADE_STEP
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_LEDS-1:0] leds_in,
    input  logic [PWM_BITS-1:0] master_brightness,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                period_start
);

    localparam int                  FDIV_W    = fdiv_width(FADE_DIV);
    localparam logic [FDIV_W-1:0]   FDIV_LAST = FDIV_W'(FADE_DIV - 1);
    // Period is LEVEL_MAX cycles so that a full-scale duty is always on.
    localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'(level_max(PWM_BITS) - 1);

    logic [FDIV_W-1:0]   r_fdiv;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                r_period_start;
    logic                w_fade_tick;
    logic                w_latch;
    logic [NUM_LEDS-1:0] w_led;

    assign w_fade_tick = (r_fdiv == FDIV_LAST);
    assign w_latch     = (r_pwm_cnt == CNT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fdiv         <= '0;
            r_pwm_cnt      <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_fdiv         <= w_fade_tick ? '0 : (r_fdiv + FDIV_W'(1));
            r_pwm_cnt      <= w_latch ? '0 : (r_pwm_cnt + PWM_BITS'(1));
            r_period_start <= (r_pwm_cnt == '0);
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_ch (
            .clock               (clock),
            .reset               (reset),
            .i_led               (leds_in[gi]),
            .i_fade_tick         (w_fade_tick),
            .i_latch             (w_latch),
            .i_pwm_cnt           (r_pwm_cnt),
            .i_master_brightness (master_brightness),
            .o_led               (w_led[gi])
        );
    end

    assign led_out      = w_led;
    assign period_start = r_period_start;

endmodule

// File: tb/tb_led_fade_driver.sv
module tb_led_fade_driver;

    localparam int NL  = 8;
    localparam int PW  = 4;
    localparam int FD  = 4;
    localparam int FS  = 3;
    localparam int MAX = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic [NL-1:0] leds_in;
    logic [PW-1:0] mb;
    logic [NL-1:0] led_out;
    logic          period_start;

    led_fade_driver #(
        .NUM_LEDS  (NL),
        .PWM_BITS  (PW),
        .FADE_DIV  (FD),
        .FADE_STEP (FS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .leds_in           (leds_in),
        .master_brightness (mb),
        .led_out           (led_out),
        .period_start      (period_start)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, written from the behavioural description
    int            m_fdiv = 0;
    int            m_pwm  = 0;
    int            m_level[NL];
    int            m_shadow[NL];
    logic [NL-1:0] m_led = '0;
    logic          m_ps  = 1'b0;

    logic [NL:0]   exp_q[$];
    logic [NL-1:0] s_led;
    logic          s_ps;
    int            meas_hi[NL];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int  n_level[NL];
        int  n_shadow[NL];
        bit  tick;
        bit  latch;
        if (reset) begin
            for (int i = 0; i < NL; i++) begin
                m_level[i]  = 0;
                m_shadow[i] = 0;
            end
            m_fdiv = 0;
            m_pwm  = 0;
            m_led  = '0;
            m_ps   = 1'b0;
        end else begin
            tick  = (m_fdiv == FD - 1);
            latch = (m_pwm == MAX - 1);
            for (int i = 0; i < NL; i++) begin
                m_led[i] = (m_pwm < m_shadow[i]);
                if (leds_in[i])
                    n_level[i] = MAX;
                else if (tick)
                    n_level[i] = (m_level[i] >= FS) ? m_level[i] - FS : 0;
                else
                    n_level[i] = m_level[i];
                n_shadow[i] = latch ? (m_level[i] * (int'(mb) + 1)) / (MAX + 1) : m_shadow[i];
            end
            for (int i = 0; i < NL; i++) begin
                m_level[i]  = n_level[i];
                m_shadow[i] = n_shadow[i];
            end
            m_ps   = (m_pwm == 0);
            m_fdiv = tick ? 0 : m_fdiv + 1;
            m_pwm  = (m_pwm + 1) % MAX;
        end
    endtask

    // Drive one clock: predict, queue, let the edge happen, pop and compare.
    task automatic tick();
        logic [NL:0] e;
        model_step();
        exp_q.push_back({m_ps, m_led});
        @(posedge clock);
        #1;
        e     = exp_q.pop_front();
        s_led = led_out;
        s_ps  = period_start;
        check_eq("led_out", 32'(led_out), 32'(e[NL-1:0]));
        check_eq("period_start", 32'(period_start), 32'(e[NL]));
    endtask

    // Sum led_out high samples over one full PWM period, optionally changing
    // master brightness at sample index chg_at of that period.
    task automatic measure(input int chg_at, input logic [PW-1:0] chg_mb);
        int guard;
        guard = 0;
        tick();
        while (s_ps !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        check_eq("period_sync", 32'(s_ps), 32'd1);
        for (int i = 0; i < NL; i++) meas_hi[i] = int'(s_led[i]);
        for (int k = 1; k < MAX; k++) begin
            if (k == chg_at) mb = chg_mb;
            tick();
            for (int i = 0; i < NL; i++) meas_hi[i] += int'(s_led[i]);
        end
    endtask

    function automatic logic [31:0] levels_or();
        return 32'(dut.g_ch[0].u_ch.r_level_p0 | dut.g_ch[1].u_ch.r_level_p0 |
                   dut.g_ch[2].u_ch.r_level_p0 | dut.g_ch[3].u_ch.r_level_p0 |
                   dut.g_ch[4].u_ch.r_level_p0 | dut.g_ch[5].u_ch.r_level_p0 |
                   dut.g_ch[6].u_ch.r_level_p0 | dut.g_ch[7].u_ch.r_level_p0);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lv_q[$];
        int exp_lv[6];
        int others;
        int g;
        exp_lv = '{15, 12, 9, 6, 3, 0};
        for (int i = 0; i < NL; i++) begin
            m_level[i]  = 0;
            m_shadow[i] = 0;
        end

        // Reset held 3 cycles with all scanner bits high
        reset   = 1'b1;
        leds_in = 8'hFF;
        mb      = 4'd15;
        repeat (3) begin
            tick();
            check_eq("rst_pwm_cnt", 32'(dut.r_pwm_cnt), 32'd0);
            check_eq("rst_led_out", 32'(led_out), 32'd0);
        end
        reset   = 1'b0;
        leds_in = 8'h00;
        tick();
        check_eq("first_period_start", 32'(period_start), 32'd1);

        // Full on: channel 0 held lit
        leds_in = 8'h01;
        repeat (20) tick();
        measure(-1, 4'd15);
        check_eq("full_on_ch0", 32'(meas_hi[0]), 32'd15);
        others = 0;
        for (int i = 1; i < NL; i++) others += meas_hi[i];
        check_eq("full_on_others", 32'(others), 32'd0);

        // Master brightness change mid-period takes effect next period
        measure(5, 4'd7);
        check_eq("scale_same_period", 32'(meas_hi[0]), 32'd15);
        measure(-1, 4'd7);
        check_eq("scale_mb7", 32'(meas_hi[0]), 32'd7);
        mb = 4'd0;
        measure(-1, 4'd0);
        check_eq("scale_mb0_pending", 32'(meas_hi[0]), 32'd7);
        measure(-1, 4'd0);
        check_eq("scale_mb0", 32'(meas_hi[0]), 32'd0);
        mb = 4'd15;

        // Fade sequence on channel 3 after a one-cycle pulse
        leds_in = 8'h08;
        tick();
        leds_in = 8'h00;
        lv_q.push_back(int'(dut.g_ch[3].u_ch.r_level_p0));
        repeat (30) begin
            tick();
            if (int'(dut.g_ch[3].u_ch.r_level_p0) != lv_q[$])
                lv_q.push_back(int'(dut.g_ch[3].u_ch.r_level_p0));
        end
        check_eq("fade_steps", 32'(lv_q.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            check_eq("fade_level", (i < lv_q.size()) ? 32'(lv_q[i]) : 32'hFFFF_FFFF, 32'(exp_lv[i]));
        check_eq("fade_floor", 32'(dut.g_ch[3].u_ch.r_level_p0), 32'd0);
        repeat (20) tick();

        // Load on the same cycle as a fade tick with level 6
        leds_in = 8'h04;
        tick();
        leds_in = 8'h00;
        g = 0;
        while (!(m_level[2] == 6 && m_fdiv == FD - 1) && g < 40) begin
            tick();
            g++;
        end
        check_eq("collide_pre_level", 32'(dut.g_ch[2].u_ch.r_level_p0), 32'd6);
        check_eq("collide_pre_tick", 32'(dut.w_fade_tick), 32'd1);
        leds_in = 8'h04;
        tick();
        leds_in = 8'h00;
        check_eq("collide_load_wins", 32'(dut.g_ch[2].u_ch.r_level_p0), 32'd15);
        repeat (10) tick();

        // Scanner sweep, then a one-cycle reset mid-fade
        for (int k = 0; k < 24; k++) begin
            leds_in = 8'(1 << ((k / 3) % NL));
            tick();
        end
        check_eq("sweep_levels_live", 32'(levels_or() != 0), 32'd1);
        reset   = 1'b1;
        leds_in = 8'hFF;
        tick();
        check_eq("midrst_levels", levels_or(), 32'd0);
        check_eq("midrst_led_out", 32'(led_out), 32'd0);
        reset   = 1'b0;
        leds_in = 8'h00;
        repeat (20) tick();
        check_eq("post_rst_idle", levels_or(), 32'd0);
        leds_in = 8'h20;
        tick();
        leds_in = 8'h00;
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
